// File: rtl/csa_pkg.sv
// Shared helpers for the pipelined carry-select adder: group count and
// parameter legality, both usable in constant expressions.
package csa_pkg;

    function automatic int group_count(input int width, input int block);
        return width / block;
    endfunction

    // Legal when WIDTH splits into whole blocks and the blocks split evenly into PIPE segments.
    function automatic bit params_ok(input int width, input int block, input int pipe);
        if (block <= 0 || width <= 0) return 1'b0;
        if (width % block != 0) return 1'b0;
        if (pipe < 1 || pipe > width / block) return 1'b0;
        return ((width / block) % pipe) == 0;
    endfunction

endpackage

// File: rtl/csa_block.sv
// Combinational dual-carry block: sums a+b for carry-in 0 and 1 so the
// incoming group carry only has to drive a mux.
module csa_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    output logic [BLOCK-1:0] sum0,
    output logic [BLOCK-1:0] sum1,
    output logic             c0,
    output logic             c1
);

    assign {c0, sum0} = {1'b0, a} + {1'b0, b};
    assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// An input rank captures operands, then PIPE stages each resolve one segment LSB first.
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int BLOCK = 8,
    parameter int PIPE  = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int G    = group_count(WIDTH, BLOCK);
    localparam int S    = G / PIPE;
    localparam int SEGW = S * BLOCK;

    if (!params_ok(WIDTH, BLOCK, PIPE)) begin : g_param_check
        $fatal(1, "csa_pipe_adder: illegal WIDTH/BLOCK/PIPE combination");
    end

    logic             w_stall;
    logic             r_in_v;
    logic             r_in_c;
    logic [WIDTH-1:0] r_in_a;
    logic [WIDTH-1:0] r_in_b;

    // A full output that is not being taken freezes every rank at once.
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_in_v <= 1'b0;
            r_in_c <= 1'b0;
            r_in_a <= '0;
            r_in_b <= '0;
        end else if (!w_stall) begin
            r_in_v <= in_valid;
            r_in_c <= sub | cin;
            r_in_a <= op1;
            r_in_b <= sub ? ~op2 : op2;
        end
    end

    for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
        localparam int LO  = gi * SEGW;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]            w_a;
        logic [REM-1:0]            w_b;
        logic                      w_cin;
        logic                      w_v;
        logic [S-1:0][BLOCK-1:0]   w_s0;
        logic [S-1:0][BLOCK-1:0]   w_s1;
        logic [S-1:0]              w_c0;
        logic [S-1:0]              w_c1;
        logic [SEGW-1:0]           w_seg;
        logic                      w_cout;
        logic [LO+SEGW-1:0]        w_sum_next;
        logic [LO+SEGW-1:0]        r_sum;
        logic                      r_c;
        logic                      r_v;

        if (gi == 0) begin : g_src
            assign w_a        = r_in_a;
            assign w_b        = r_in_b;
            assign w_cin      = r_in_c;
            assign w_v        = r_in_v;
            assign w_sum_next = w_seg;
        end else begin : g_src
            assign w_a        = g_stage[gi-1].g_fwd.r_a;
            assign w_b        = g_stage[gi-1].g_fwd.r_b;
            assign w_cin      = g_stage[gi-1].r_c;
            assign w_v        = g_stage[gi-1].r_v;
            assign w_sum_next = {w_seg, g_stage[gi-1].r_sum};
        end

        for (genvar gj = 0; gj < S; gj++) begin : g_grp
            csa_block #(.BLOCK(BLOCK)) u_blk (
                .a    (w_a[gj*BLOCK +: BLOCK]),
                .b    (w_b[gj*BLOCK +: BLOCK]),
                .sum0 (w_s0[gj]),
                .sum1 (w_s1[gj]),
                .c0   (w_c0[gj]),
                .c1   (w_c1[gj])
            );
        end

        // Group carries ripple only through the select muxes within the segment.
        always_comb begin
            logic v_carry;
            v_carry = w_cin;
            w_seg   = '0;
            for (int j = 0; j < S; j++) begin
                w_seg[j*BLOCK +: BLOCK] = v_carry ? w_s1[j] : w_s0[j];
                v_carry                 = v_carry ? w_c1[j] : w_c0[j];
            end
            w_cout = v_carry;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_sum <= '0;
                r_c   <= 1'b0;
                r_v   <= 1'b0;
            end else if (!w_stall) begin
                r_sum <= w_sum_next;
                r_c   <= w_cout;
                r_v   <= w_v;
            end
        end

        if (gi < PIPE - 1) begin : g_fwd
            logic [REM-SEGW-1:0] r_a;
            logic [REM-SEGW-1:0] r_b;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall) begin
                    r_a <= w_a[REM-1:SEGW];
                    r_b <= w_b[REM-1:SEGW];
                end
            end
        end else begin : g_last
            logic r_ovf;
            // Carry into the MSB is recovered as a^b^sum at that bit.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall) begin
                    r_ovf <= w_a[SEGW-1] ^ w_b[SEGW-1] ^ w_seg[SEGW-1] ^ w_cout;
                end
            end
        end
    end

    assign out_valid = g_stage[PIPE-1].r_v;
    assign sum       = g_stage[PIPE-1].r_sum;
    assign cout      = g_stage[PIPE-1].r_c;
    assign ovf       = g_stage[PIPE-1].g_last.r_ovf;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed bench for csa_pipe_adder at WIDTH=64, BLOCK=8, PIPE=2:
// reset, single vectors with latency, a backpressured stream and a mid-stream reset.
module tb_csa_pipe_adder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int n_vec  = 0;
    int n_miss = 0;

    csa_pipe_adder #(.WIDTH(64), .BLOCK(8), .PIPE(2)) dut (
        .clock     (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic        sb;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[8];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic run_vec(input int k);
        int lat;
        @(negedge clk);
        op1       = vecs[k].a;
        op2       = vecs[k].b;
        cin       = vecs[k].ci;
        sub       = vecs[k].sb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check_val($sformatf("v%0d_latency", k), 64'(lat), 64'd2);
        check_val($sformatf("v%0d_sum", k), sum, vecs[k].s);
        check_val($sformatf("v%0d_cout", k), 64'(cout), 64'(vecs[k].co));
        check_val($sformatf("v%0d_ovf", k), 64'(ovf), 64'(vecs[k].ov));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'hbbbb_cdcd_aaaa_1111, 64'hffff_ffff_ffff_dddd, 1'b0, 1'b0, 64'hbbbb_cdcd_aaa9_eeee, 1'b1, 1'b0};
        vecs[1] = '{64'hffff_ffff_ffff_ffff, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7fff_ffff_ffff_ffff, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hffff_ffff_ffff_fffe, 1'b0, 1'b0};
        vecs[4] = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7fff_ffff_ffff_ffff, 1'b1, 1'b1};
        vecs[6] = '{64'h0123_4567_89ab_cdef, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 64'h1234_5678_9abc_df01, 1'b0, 1'b0};
        vecs[7] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};

        // Reset held with in_valid asserted must not let anything through.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        op1       = 64'h1234;
        op2       = 64'h4321;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("rst%0d_out_valid", c), 64'(out_valid), 64'd0);
            check_val($sformatf("rst%0d_sum", c), sum, 64'd0);
            check_val($sformatf("rst%0d_cout", c), 64'(cout), 64'd0);
            check_val($sformatf("rst%0d_ovf", c), 64'(ovf), 64'd0);
            check_val($sformatf("rst%0d_in_ready", c), 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;

        for (int k = 0; k < 8; k++) run_vec(k);

        // Backpressure: six back-to-back i+i operands, out_ready low for 3 cycles.
        begin
            bit mv[3];
            int idx;
            int nout;
            bit fire;
            bit exp_stall;
            mv   = '{0, 0, 0};
            idx  = 0;
            nout = 0;
            @(posedge clk);
            for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
                @(negedge clk);
                out_ready = !(cyc >= 4 && cyc < 7);
                sub = 1'b0;
                cin = 1'b0;
                if (idx < 6) begin
                    op1      = 64'(idx + 1);
                    op2      = 64'(idx + 1);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                exp_stall = mv[2] && !out_ready;
                check_val($sformatf("bp_c%0d_in_ready", cyc), 64'(in_ready), 64'(!exp_stall));
                check_val($sformatf("bp_c%0d_out_valid", cyc), 64'(out_valid), 64'(mv[2]));
                if (out_valid && out_ready) begin
                    check_val($sformatf("bp_out%0d_sum", nout), sum, 64'(2 * (nout + 1)));
                    nout++;
                end
                fire = in_valid && in_ready;
                @(posedge clk);
                if (!exp_stall) begin
                    mv[2] = mv[1];
                    mv[1] = mv[0];
                    mv[0] = fire;
                end
                if (fire) idx++;
            end
            check_val("bp_result_count", 64'(nout), 64'd6);
            #1 in_valid = 1'b0;
            out_ready = 1'b1;
        end

        // Mid-stream reset drops the in-flight token and nothing emerges afterwards.
        @(negedge clk);
        op1      = 64'd9;
        op2      = 64'd9;
        sub      = 1'b0;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_sum", sum, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("postrst%0d_out_valid", c), 64'(out_valid), 64'd0);
        end
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
